// File: rtl/fft_seq_pkg.sv
// Shared definitions for the FFT frame sequencer: reader states and sizing constants.
package fft_seq_pkg;

  localparam int FRAME_LEN_DEFAULT = 1024;
  localparam int COUNT_W           = 16;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    STREAM    = 2'd1,
    WAIT_DONE = 2'd2
  } rd_state_t;

endpackage

// File: rtl/fft_frame_sequencer_if.sv
// Valid/ready/last sample stream from the frame sequencer into the FFT core.
interface fft_frame_sequencer_if #(
  parameter int SAMPLE_WIDTH = 8
);

  logic [SAMPLE_WIDTH-1:0] fft_data_out;
  logic                    fft_valid_out;
  logic                    fft_last_out;
  logic                    fft_ready_in;

  modport master (
    output fft_data_out,
    output fft_valid_out,
    output fft_last_out,
    input  fft_ready_in
  );

  modport slave (
    input  fft_data_out,
    input  fft_valid_out,
    input  fft_last_out,
    output fft_ready_in
  );

endinterface

// File: rtl/frame_bank_ram.sv
// Simple dual-port frame memory; address MSB selects the bank, registered read with 1-cycle latency.
module frame_bank_ram #(
  parameter int DEPTH = 2048,
  parameter int WIDTH = 8
) (
  input  logic                     clk_m,
  input  logic                     wr_en,
  input  logic [$clog2(DEPTH)-1:0] wr_addr,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     rd_en,
  input  logic [$clog2(DEPTH)-1:0] rd_addr,
  output logic [WIDTH-1:0]         rd_data
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge clk_m) begin
    if (wr_en) mem[wr_addr] <= wr_data;
    if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fft_frame_sequencer.sv
// Ping-pong frame controller: fills one bank from the window while the other streams to the FFT.
//   state     | meaning
//   IDLE      | no bank selected, waiting for a full bank
//   STREAM    | reading the selected bank out through the output register
//   WAIT_DONE | frame handed over, waiting for the peak finder to finish
module fft_frame_sequencer
  import fft_seq_pkg::*;
#(
  parameter int FRAME_LEN    = FRAME_LEN_DEFAULT,
  parameter int SAMPLE_WIDTH = 8
) (
  input  logic                        clk_in,
  input  logic                        rst_in,
  input  logic                        enable_in,
  input  logic [SAMPLE_WIDTH-1:0]     sample_in,
  input  logic                        sample_valid_in,
  fft_frame_sequencer_if.master       fft_if,
  input  logic                        done_in,
  output logic [COUNT_W-1:0]          frame_count_out,
  output logic [COUNT_W-1:0]          overrun_count_out,
  output logic                        busy_out
);

  localparam int            IW       = $clog2(FRAME_LEN);
  localparam logic [IW-1:0] IDX_LAST = IW'(FRAME_LEN - 1);

  rd_state_t         state, state_nxt;
  logic              wr_bank;
  logic [IW-1:0]     wr_idx;
  logic [1:0]        full;
  logic              rd_bank;
  logic [IW-1:0]     rd_idx;
  logic              rd_issued;
  logic              pipe_valid;
  logic              pipe_last;
  logic [SAMPLE_WIDTH-1:0] ram_q;

  logic wr_fire, frame_done, other_bank, other_free;
  logic xfer, last_xfer, adv, issue;

  assign wr_fire    = sample_valid_in && enable_in;
  assign frame_done = wr_fire && (wr_idx == IDX_LAST);
  assign other_bank = ~wr_bank;
  assign xfer       = fft_if.fft_valid_out && fft_if.fft_ready_in;
  assign last_xfer  = xfer && fft_if.fft_last_out;
  // A bank released by the reader this very cycle counts as free.
  assign other_free = !full[other_bank] || (last_xfer && (rd_bank == other_bank));
  assign adv        = !fft_if.fft_valid_out || fft_if.fft_ready_in;
  assign issue      = (state == STREAM) && !rd_issued && adv;
  assign busy_out   = (state != IDLE);

  frame_bank_ram #(
    .DEPTH (2 * FRAME_LEN),
    .WIDTH (SAMPLE_WIDTH)
  ) u_ram (
    .clk_m   (clk_in),
    .wr_en   (wr_fire),
    .wr_addr ({wr_bank, wr_idx}),
    .wr_data (sample_in),
    .rd_en   (issue),
    .rd_addr ({rd_bank, rd_idx}),
    .rd_data (ram_q)
  );

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:      if (|full)     state_nxt = STREAM;
      STREAM:    if (last_xfer) state_nxt = WAIT_DONE;
      WAIT_DONE: if (done_in)   state_nxt = IDLE;
      default:                  state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      state                <= IDLE;
      wr_bank              <= 1'b0;
      wr_idx               <= '0;
      full                 <= '0;
      rd_bank              <= 1'b0;
      rd_idx               <= '0;
      rd_issued            <= 1'b0;
      pipe_valid           <= 1'b0;
      pipe_last            <= 1'b0;
      fft_if.fft_data_out  <= '0;
      fft_if.fft_valid_out <= 1'b0;
      fft_if.fft_last_out  <= 1'b0;
      frame_count_out      <= '0;
      overrun_count_out    <= '0;
    end else begin
      state <= state_nxt;

      if (!enable_in) begin
        wr_idx <= '0;
      end else if (wr_fire) begin
        wr_idx <= wr_idx + 1'b1;
        if (frame_done) begin
          if (other_free) wr_bank <= other_bank;
          else if (overrun_count_out != '1) overrun_count_out <= overrun_count_out + 1'b1;
        end
      end

      if (last_xfer) full[rd_bank] <= 1'b0;
      if (frame_done && other_free) full[wr_bank] <= 1'b1;

      if ((state == IDLE) && (|full)) begin
        rd_bank   <= !full[0];
        rd_idx    <= '0;
        rd_issued <= 1'b0;
      end

      // Two-stage pipe (RAM output, then output register) advancing only when the FFT can take data.
      if (adv) begin
        fft_if.fft_data_out  <= pipe_valid ? ram_q : '0;
        fft_if.fft_valid_out <= pipe_valid;
        fft_if.fft_last_out  <= pipe_last;
        pipe_valid           <= issue;
        pipe_last            <= issue && (rd_idx == IDX_LAST);
      end

      if (issue) begin
        rd_idx <= rd_idx + 1'b1;
        if (rd_idx == IDX_LAST) rd_issued <= 1'b1;
      end

      if (last_xfer) frame_count_out <= frame_count_out + 1'b1;
    end
  end

endmodule
